uart_rx: RTL

Serial receiver that sits directly downstream of `uart_tx` on the board link. It oversamples the asynchronous `rx_pin` at `clk` rate and recovers 8N1-style frames: one start bit, `BIT_PER_WORD+1` data bits LSB first, and one stop bit. Each good word is presented on `data` with a one-cycle `data_ready` strobe, which is directly compatible with the rising-edge capture of `uart_tx`, so a loopback/echo needs no glue. Bad frames are flagged, not delivered.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common with uart_tx, default timing
// parameters, led status codes and the 2-of-3 majority helper.
package uart_pkg;

  localparam int DELAY_FRAMES_DEF = 2812;
  localparam int BIT_PER_WORD_DEF = 7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam logic [5:0] LED_IDLE = 6'd1;
  localparam logic [5:0] LED_RX   = 6'd2;
  localparam logic [5:0] LED_ERR  = 6'd4;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side link bundle: serial line in, recovered word and status out.
interface uart_rx_if #(
  parameter int BIT_PER_WORD = 7
);
  logic                  rx_pin;
  logic [BIT_PER_WORD:0] data;
  logic                  data_ready;
  logic                  frame_error;
  logic                  busy;
  logic [5:0]            led;

  modport master (
    input  rx_pin,
    output data, data_ready, frame_error, busy, led
  );

  modport slave (
    output rx_pin,
    input  data, data_ready, frame_error, busy, led
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // metastability filter chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, BIT_PER_WORD+1 data bits LSB first, one stop bit.
// Optional 2-of-3 sample voting is enabled with the UART_RX_MAJORITY_EN macro.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF,
  parameter int BIT_PER_WORD = BIT_PER_WORD_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);
  localparam int HALF  = DELAY_FRAMES / 2;
  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam int BIT_W = (BIT_PER_WORD > 0) ? $clog2(BIT_PER_WORD + 1) : 1;
  localparam logic [CNT_W:0]   DF_C   = DELAY_FRAMES[CNT_W:0];
  localparam logic [CNT_W:0]   HALF_C = HALF[CNT_W:0];
  localparam logic [BIT_W-1:0] LAST_C = BIT_PER_WORD[BIT_W-1:0];

  logic                  rx_s;
  logic                  sample_s;
  logic [CNT_W:0]        cnt_inc_s;

  logic [2:0]            state_r,   state_s;
  logic [CNT_W-1:0]      cnt_r,     cnt_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic [BIT_PER_WORD:0] shift_r,   shift_s;
  logic [BIT_PER_WORD:0] data_r,    data_s;
  logic                  ready_r,   ready_s;
  logic                  ferr_r,    ferr_s;
  logic                  busy_r,    busy_s;
  logic [5:0]            led_r,     led_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx_pin),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // two previous synchronized samples for voting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_s};
    end
  end

  assign sample_s = maj3({hist_r, rx_s});
`else
  assign sample_s = rx_s;
`endif

  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

  // frame sequencing and next-value computation
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    data_s    = data_r;
    ready_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_inc_s == HALF_C) begin
          cnt_s = {CNT_W{1'b0}};
          if (!sample_s) begin
            bit_cnt_s = {BIT_W{1'b0}};
            state_s   = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      ST_DATA: begin
        if (cnt_inc_s == DF_C) begin
          cnt_s              = {CNT_W{1'b0}};
          shift_s[bit_cnt_r] = sample_s;
          if (bit_cnt_r == LAST_C) begin
            state_s = ST_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      ST_STOP: begin
        if (cnt_inc_s == DF_C) begin
          cnt_s = {CNT_W{1'b0}};
          if (sample_s) begin
            data_s  = shift_r;
            ready_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_WAIT_IDLE;
          end
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      ST_WAIT_IDLE: begin
        // a break or stuck-low line holds us here until the line is released
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // status outputs track the state being entered so they are registered with it
  always_comb begin
    busy_s = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE:      led_s = LED_IDLE;
      ST_WAIT_IDLE: led_s = LED_ERR;
      ST_START,
      ST_DATA,
      ST_STOP:      led_s = LED_RX;
      default:      led_s = LED_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {(BIT_PER_WORD+1){1'b0}};
      data_r    <= {(BIT_PER_WORD+1){1'b0}};
      ready_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
      led_r     <= LED_IDLE;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      ferr_r    <= ferr_s;
      busy_r    <= busy_s;
      led_r     <= led_s;
    end
  end

  assign bus.data        = data_r;
  assign bus.data_ready  = ready_r;
  assign bus.frame_error = ferr_r;
  assign bus.busy        = busy_r;
  assign bus.led         = led_r;
endmodule
